// File: rtl/dmem_access_sequencer_pkg.sv
// Shared types for the lc3b MEM-stage data-memory sequencer: opcodes, FSM states
// and opcode classification helpers.
package dmem_access_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_BR   = 4'b0000,
    OP_ADD  = 4'b0001,
    OP_LDB  = 4'b0010,
    OP_STB  = 4'b0011,
    OP_JSR  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_LDR  = 4'b0110,
    OP_STR  = 4'b0111,
    OP_RTI  = 4'b1000,
    OP_NOT  = 4'b1001,
    OP_LDI  = 4'b1010,
    OP_STI  = 4'b1011,
    OP_JMP  = 4'b1100,
    OP_SHF  = 4'b1101,
    OP_LEA  = 4'b1110,
    OP_TRAP = 4'b1111
  } lc3b_opcode;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    IND  = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } dmem_seq_state_t;

  function automatic logic is_dmem_op(input lc3b_opcode op);
    return op inside {OP_LDR, OP_STR, OP_LDB, OP_STB, OP_LDI, OP_STI, OP_TRAP};
  endfunction

  function automatic logic is_indirect_op(input lc3b_opcode op);
    return op inside {OP_LDI, OP_STI};
  endfunction

  function automatic logic is_byte_op(input lc3b_opcode op);
    return op inside {OP_LDB, OP_STB};
  endfunction

  // Ops whose final access writes the first bus access (STI writes only on its second access).
  function automatic logic is_direct_store(input lc3b_opcode op);
    return op inside {OP_STR, OP_STB};
  endfunction

  function automatic logic is_load_result(input lc3b_opcode op);
    return op inside {OP_LDR, OP_LDB, OP_LDI, OP_TRAP};
  endfunction

endpackage

// File: rtl/dmem_access_sequencer_lane_align.sv
// Byte-lane steering: lane select generation, store-byte replication and
// load-byte extraction with sign extension.
module dmem_lane_align #(
  parameter int DATA_WIDTH = 16,
  parameter int LANE_W     = (DATA_WIDTH > 8) ? $clog2(DATA_WIDTH / 8) : 1
) (
  input  logic                      st_byte,
  input  logic [LANE_W-1:0]         st_lane,
  input  logic [DATA_WIDTH-1:0]     store_data,
  input  logic                      ld_byte,
  input  logic [LANE_W-1:0]         ld_lane,
  input  logic [DATA_WIDTH-1:0]     rdata,
  output logic [DATA_WIDTH/8-1:0]   sel,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     load_val
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [LANES-1:0]      one_hot;
  logic [DATA_WIDTH-1:0] shifted;
  logic signed [7:0]     ld_byte_val;

  always_comb begin
    one_hot     = LANES'(1) << st_lane;
    sel         = st_byte ? one_hot : '1;
    // Byte stores put the byte on every lane; sel picks the one that lands.
    wdata       = st_byte ? {LANES{store_data[7:0]}} : store_data;
    shifted     = rdata >> {ld_lane, 3'b000};
    ld_byte_val = shifted[7:0];
    load_val    = ld_byte ? DATA_WIDTH'(ld_byte_val) : rdata;
  end

endmodule

// File: rtl/dmem_access_sequencer.sv
// MEM-stage data-memory sequencer: runs one- or two-access ops on a Wishbone-style
// bus, holds mem_stall until retirement, and aborts stuck accesses via a watchdog.
module dmem_access_sequencer
  import dmem_access_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    op_valid,
  input  lc3b_opcode              opcode,
  input  logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic                    flush,
  input  logic                    dmem_ack,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata,
  output logic                    dmem_cyc,
  output logic                    dmem_stb,
  output logic                    dmem_we,
  output logic [DATA_WIDTH/8-1:0] dmem_sel,
  output logic [ADDR_WIDTH-1:0]   dmem_adr,
  output logic [DATA_WIDTH-1:0]   dmem_wdata,
  output logic                    mem_stall,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic                    load_valid,
  output logic                    timeout_err,
  output dmem_seq_state_t         dbg_state
);

  // Bus handshake: a transfer completes in any cycle where cyc & stb & ack are all high;
  // cyc/stb stay asserted (with stable adr/we/sel/wdata) until that cycle or a watchdog abort.

  localparam int LANES  = DATA_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CNT_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam bit WD_EN  = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0]      EXP_CNT   = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(LANES - 1);

  dmem_seq_state_t       state, state_nxt;
  lc3b_opcode            op_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  cyc_q;
  logic                  we_q;
  logic [LANES-1:0]      sel_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic                  load_valid_q;
  logic                  timeout_q;

  logic                  start;
  logic                  in_bus;
  logic                  expire;
  logic                  ptr_ack;
  logic [LANES-1:0]      lane_sel;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] ld_val;

  dmem_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_lane_align (
    .st_byte    (is_byte_op(opcode)),
    .st_lane    (mem_addr[LANE_W-1:0]),
    .store_data (store_data),
    .ld_byte    (op_q == OP_LDB),
    .ld_lane    (adr_q[LANE_W-1:0]),
    .rdata      (dmem_rdata),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .load_val   (ld_val)
  );

  always_comb begin
    start   = (state == IDLE) && op_valid && is_dmem_op(opcode) && !flush;
    in_bus  = (state == REQ) || (state == IND);
    // An ack in the expiry cycle wins over the watchdog.
    expire  = WD_EN && in_bus && !dmem_ack && (cnt_q == EXP_CNT);
    ptr_ack = (state == REQ) && dmem_ack && is_indirect_op(op_q);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (dmem_ack)    state_nxt = is_indirect_op(op_q) ? IND : DONE;
        else if (expire) state_nxt = ERR;
      end
      IND: begin
        if (dmem_ack)    state_nxt = DONE;
        else if (expire) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= OP_BR;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      sel_q        <= '0;
      adr_q        <= '0;
      wdata_q      <= '0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      cyc_q        <= (state_nxt == REQ) || (state_nxt == IND);
      load_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      if (start) begin
        op_q    <= opcode;
        cnt_q   <= '0;
        adr_q   <= is_byte_op(opcode) ? mem_addr : (mem_addr & WORD_MASK);
        wdata_q <= lane_wdata;
        sel_q   <= lane_sel;
        we_q    <= is_direct_store(opcode);
      end
      if (in_bus) begin
        if (ptr_ack) begin
          // First access of LDI/STI fetched the pointer; retarget for the second access.
          cnt_q <= '0;
          adr_q <= ADDR_WIDTH'(dmem_rdata) & WORD_MASK;
          we_q  <= (op_q == OP_STI);
          sel_q <= '1;
        end else if (dmem_ack) begin
          cnt_q <= '0;
          we_q  <= 1'b0;
          if (is_load_result(op_q)) begin
            load_data_q  <= ld_val;
            load_valid_q <= 1'b1;
          end
        end else begin
          if (WD_EN) cnt_q <= cnt_q + CNT_W'(1);
          if (expire) begin
            timeout_q <= 1'b1;
            we_q      <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    mem_stall   = start || in_bus;
    dmem_cyc    = cyc_q;
    dmem_stb    = cyc_q;
    dmem_we     = we_q;
    dmem_sel    = sel_q;
    dmem_adr    = adr_q;
    dmem_wdata  = wdata_q;
    load_data   = load_data_q;
    load_valid  = load_valid_q;
    timeout_err = timeout_q;
    dbg_state   = state;
  end

endmodule
